credit_tx_fifo: RTL and testbench

CREDIT_TX_FIFO -- requirements
Module: credit_tx_fifo

---
 rtl/credit_tx_fifo.sv | 98 +++++++++
 tb/tb_credit_tx_fifo.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/credit_tx_fifo.sv
// rtl/credit_tx_fifo.sv - credit-gated transmit staging FIFO feeding a link with no back-pressure
// Flits leave only while the far receiver has granted credits; yumi pulses return them.
module credit_tx_fifo #(
    parameter int DATA_WIDTH   = 64,
    parameter int FIFO_DEPTH   = 4,
    parameter int CREDIT_WIDTH = 3,
    parameter int INIT_CREDITS = 1,
    parameter int MAX_CREDITS  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [DATA_WIDTH-1:0]           in_data,
    output logic                            in_ready,
    input  logic [31:0]                     dest,
    output logic                            link_valid,
    output logic [DATA_WIDTH-1:0]           link_data,
    output logic [31:0]                     link_dest,
    input  logic                            yumi,
    output logic [CREDIT_WIDTH-1:0]         credits,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic [31:0]                     sent_count,
    output logic                            credit_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SEND, STALL} state_t;

    state_t                    state_q, state_d;
    logic [DATA_WIDTH+31:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]             count_q, count_d;
    logic [CREDIT_WIDTH-1:0]   credits_q, credits_d;
    logic [31:0]               sent_q;
    logic                      err_q, err_d;
    logic                      push, send;
    logic [DATA_WIDTH+31:0]    head;

    assign in_ready = (count_q != CW'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    // SEND is registered from the next-cycle occupancy and credits, so it equals (count != 0 && credits != 0).
    assign send     = (state_q == SEND);
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        count_d   = count_q + CW'(push) - CW'(send);
        credits_d = credits_q;
        err_d     = err_q;
        if (yumi && !send && credits_q == CREDIT_WIDTH'(MAX_CREDITS)) begin
            err_d = 1'b1;
        end else begin
            credits_d = credits_q - CREDIT_WIDTH'(send) + CREDIT_WIDTH'(yumi);
        end
        if (count_d == '0) begin
            state_d = IDLE;
        end else if (credits_d == '0) begin
            state_d = STALL;
        end else begin
            state_d = SEND;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            credits_q <= CREDIT_WIDTH'(INIT_CREDITS);
            sent_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            credits_q <= credits_d;
            err_q     <= err_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (send) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                sent_q   <= sent_q + 32'd1;
            end
        end
    end

    // Storage carries no reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= {dest, in_data};
    end

    assign link_valid = send;
    assign link_data  = send ? head[DATA_WIDTH-1:0]  : '0;
    assign link_dest  = send ? head[DATA_WIDTH+:32]  : '0;
    assign credits    = credits_q;
    assign fifo_count = count_q;
    assign sent_count = sent_q;
    assign credit_err = err_q;
endmodule

// File: tb/tb_credit_tx_fifo.sv
// tb/tb_credit_tx_fifo.sv - scoreboard bench for credit_tx_fifo
module tb_credit_tx_fifo;
    localparam int DW = 64;
    localparam int DEPTH = 4;
    localparam int CRW = 3;
    localparam int INIT = 1;
    localparam int MAXC = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic [DW-1:0]  in_data = '0;
    logic           in_ready;
    logic [31:0]    dest = '0;
    logic           link_valid;
    logic [DW-1:0]  link_data;
    logic [31:0]    link_dest;
    logic           yumi = 1'b0;
    logic [CRW-1:0] credits;
    logic [2:0]     fifo_count;
    logic [31:0]    sent_count;
    logic           credit_err;

    credit_tx_fifo #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CREDIT_WIDTH(CRW),
        .INIT_CREDITS(INIT), .MAX_CREDITS(MAXC)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .dest(dest), .link_valid(link_valid),
        .link_data(link_data), .link_dest(link_dest), .yumi(yumi),
        .credits(credits), .fifo_count(fifo_count), .sent_count(sent_count),
        .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   d;
        logic [DW-1:0] p;
    } ent_t;

    ent_t        sb[$];
    int          m_cr;
    int unsigned m_sent;
    bit          m_err;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, compare the current outputs, advance the model.
    task automatic step(input bit r, input bit v, input logic [DW-1:0] d, input logic [31:0] dst, input bit y);
        bit   exp_send, exp_push;
        ent_t e;
        @(negedge clk);
        rst = r; in_valid = v; in_data = d; dest = dst; yumi = y;
        exp_send = (sb.size() != 0) && (m_cr != 0);
        exp_push = v && (sb.size() != DEPTH);
        chk("in_ready",   128'(in_ready),   128'(sb.size() != DEPTH));
        chk("link_valid", 128'(link_valid), 128'(exp_send));
        chk("credits",    128'(credits),    128'(m_cr));
        chk("fifo_count", 128'(fifo_count), 128'(sb.size()));
        chk("sent_count", 128'(sent_count), 128'(m_sent));
        chk("credit_err", 128'(credit_err), 128'(m_err));
        if (exp_send) begin
            chk("link_data", 128'(link_data), 128'(sb[0].p));
            chk("link_dest", 128'(link_dest), 128'(sb[0].d));
        end else begin
            chk("link_data_idle", 128'(link_data), 128'(0));
            chk("link_dest_idle", 128'(link_dest), 128'(0));
        end
        if (r) begin
            sb.delete();
            m_cr = INIT; m_sent = 0; m_err = 1'b0;
        end else begin
            if (exp_send) void'(sb.pop_front());
            if (exp_push) begin
                e.d = dst; e.p = d;
                sb.push_back(e);
            end
            if (y && !exp_send && m_cr == MAXC) m_err = 1'b1;
            else m_cr = m_cr - int'(exp_send) + int'(y);
            if (exp_send) m_sent++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0);
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [31:0] dst);
        step(0, 1, d, dst, 0);
    endtask

    task automatic do_reset();
        step(1, 0, '0, '0, 0);
    endtask

    initial begin
        m_cr = INIT; m_sent = 0; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",   128'(in_ready),   128'(1));
        chk("rst_link_valid", 128'(link_valid), 128'(0));
        chk("rst_link_data",  128'(link_data),  128'(0));
        chk("rst_credits",    128'(credits),    128'(INIT));
        chk("rst_fifo_count", 128'(fifo_count), 128'(0));

        // single word
        push(64'hdeedabba_cafeface, 32'd2);
        step(0, 0, '0, '0, 0);
        chk("single_dest",  128'(link_dest), 128'(2));
        chk("single_data",  128'(link_data), 128'(64'hdeedabba_cafeface));
        idle(2);
        chk("single_sent",  128'(sent_count), 128'(1));
        chk("single_cr",    128'(credits),    128'(0));

        // credit stall then release, order preserved
        do_reset();
        for (int i = 0; i < 3; i++) push(64'h1000 + 64'(i), 32'(10 + i));
        idle(3);
        chk("stall_lv", 128'(link_valid), 128'(0));
        step(0, 0, '0, '0, 1);
        idle(2);
        step(0, 0, '0, '0, 1);
        idle(3);

        // full FIFO with no credits, fifth offer ignored
        do_reset();
        push(64'h55, 32'd1);
        idle(1);
        for (int i = 0; i < 5; i++) push(64'h2000 + 64'(i), 32'(20 + i));
        chk("full_ready", 128'(in_ready),   128'(0));
        chk("full_count", 128'(fifo_count), 128'(4));
        step(0, 1, 64'h2fff, 32'd99, 1);
        step(0, 1, 64'h2ffe, 32'd98, 0);
        for (int i = 0; i < 4; i++) step(0, 0, '0, '0, 1);
        idle(3);

        // send and yumi together keep credits steady
        do_reset();
        step(0, 1, 64'h3000, 32'd30, 1);
        step(0, 1, 64'h3001, 32'd31, 1);
        step(0, 0, '0, '0, 1);
        step(0, 0, '0, '0, 1);
        idle(2);

        // overflow sets a sticky error
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, '0, '0, 1);
        step(0, 0, '0, '0, 1);
        idle(3);
        chk("ovf_err", 128'(credit_err), 128'(1));
        chk("ovf_cr",  128'(credits),    128'(MAXC));

        // reset mid-operation discards everything
        do_reset();
        push(64'h77, 32'd7);
        for (int i = 0; i < 3; i++) push(64'h4000 + 64'(i), 32'(40 + i));
        do_reset();
        idle(2);
        chk("mid_cr", 128'(credits), 128'(INIT));

        // random traffic, yumi only when it cannot overflow
        do_reset();
        for (int i = 0; i < 300; i++) begin
            bit y;
            y = ($urandom_range(0, 2) == 0) && (m_cr < MAXC - 1);
            step(0, bit'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom, y);
        end
        for (int i = 0; i < 12; i++) step(0, 0, '0, '0, m_cr < MAXC - 1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
